pc_fetch_sequencer: RTL and testbench
=====================================

// Module: pc_fetch_sequencer
// PURPOSE
//  Owns the program counter. Sequences instruction fetch over a req/ack handshake to instruction memory.
//  Hands fetched words to decode over a valid/ready handshake.
//  Applies redirects: branch = PC+4+sext16<<2, jump = PC+4+sext26<<2 (26->32 sign extend), jr = register target.
//  Sits between the imem port and the decode stage of the MIPS core.
// PARAMETERS
//  RESET_PC   32'h0000_0000  fetch address loaded on reset
// PORTS
//  clk            in   1   single clock; all state on posedge
//  reset          in   1   synchronous, active-high
//  imem_req       out  1   fetch request; held until imem_ack
//  imem_addr      out  32  fetch address; stable while imem_req=1
//  imem_ack       in   1   one-cycle ack; imem_rdata valid same cycle
//  imem_rdata     in   32  fetched instruction word
//  instr_valid    out  1   instr_out/instr_pc valid to decode
//  instr_ready    in   1   decode accepts when valid&ready
//  instr_out      out  32  held instruction word
//  instr_pc       out  32  address of instr_out
//  redirect_valid in   1   one-cycle redirect strobe from execute
//  redirect_type  in   2   00 branch, 01 jump, 10 jr, 11 reserved (ignored)
//  redirect_pc    in   32  PC of the redirecting instruction
//  branch_imm16   in   16  branch offset, words, signed
//  jump_imm26     in   26  jump offset, words, signed
//  jr_target      in   32  absolute jr target
// BEHAVIOUR
//  Reset: state=IDLE, fetch_pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_out=0, instr_pc=0.
//  States: IDLE, FETCH, HOLD, DISCARD.
//  IDLE: always -> FETCH next cycle; redirect in IDLE is applied to fetch_pc.
//  FETCH: imem_req=1, imem_addr=fetch_pc.
//   - ack & no redirect: latch instr_out=rdata, instr_pc=fetch_pc; fetch_pc+=4; -> HOLD.
//     Decode sees instr_valid=1 one cycle after ack.
//   - ack & redirect: drop rdata, fetch_pc=target, stay FETCH; req re-asserts with new addr next cycle.
//   - no ack & redirect: pend_pc=target; -> DISCARD. The request is not withdrawn.
//  HOLD: instr_valid=1, imem_req=0.
//   - redirect: instr_valid=0 next cycle, fetch_pc=target, -> FETCH. Redirect beats ready on the same cycle.
//   - ready & no redirect: -> FETCH. Valid is low next cycle; no combinational ready->req path.
//  DISCARD: imem_req=1 at the old addr.
//   - further redirect overwrites pend_pc; a redirect on the ack cycle wins.
//   - on ack: drop rdata, fetch_pc=pend_pc, -> FETCH.
//  Targets (mod 2^32): branch = redirect_pc+4+({{14{imm16[15]}},imm16,2'b00});
//   jump = redirect_pc+4+({{4{imm26[25]}},imm26,2'b00}); jr = {jr_target[31:2],2'b00}.
//  redirect_type=11: treated as no redirect.
//  fetch_pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000 silently.
//  Reset mid-operation, any state: returns to the reset values next cycle; any outstanding ack is ignored.
//  imem_ack while imem_req=0 is ignored.
// STRUCTURE
//  mips_pkg: redirect_t enum (RD_BRANCH, RD_JUMP, RD_JR), fetch_state_t enum,
//   sext16_32 / sext26_32 functions.
//  Sub-module pc_target_calc (combinational): redirect_type, redirect_pc, imms, jr_target -> target[31:0].
//  Top holds the FSM, fetch_pc, pend_pc and the output registers.
// TESTING
//  1 reset, imem acks after 2 cycles, ready=1: addrs 0x0,0x4,0x8 in order; instr_pc matches; first valid 1 cycle after ack.
//  2 HOLD, instr_ready=0 for 5 cycles: instr_valid/instr_out stable, imem_req=0 throughout.
//  3 branch, redirect_pc=0x100, imm16=16'hFFFE in HOLD: valid drops, next imem_addr=0x0FC.
//  4 jump, redirect_pc=0x40, imm26=26'h3FFFFFF during an unacked FETCH:
//    old addr held to ack, its data dropped, next imem_addr=0x40; second redirect (jr 0x203) in DISCARD -> addr 0x200.
//  5 RESET_PC=32'hFFFF_FFFC: second fetch addr 0x0; reset asserted in DISCARD -> req=0, addr=RESET_PC, late ack ignored.
//  6 redirect and ack same FETCH cycle (jr 0x1000): rdata dropped, no valid pulse, next addr 0x1000;
//    redirect_type=11 has no effect.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared types and helpers for the MIPS fetch front end.
//   redirect_t    : encodings of redirect_type (2'b11 is reserved, no redirect)
//   fetch_state_t : fetch sequencer FSM states
//   sext16_32 / sext26_32 : sign extension of branch / jump word offsets
package mips_pkg;

   typedef enum logic [1:0] {
      RD_BRANCH = 2'b00,
      RD_JUMP   = 2'b01,
      RD_JR     = 2'b10
   } redirect_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_FETCH   = 2'b01,
      ST_HOLD    = 2'b10,
      ST_DISCARD = 2'b11
   } fetch_state_t;

   function automatic logic [31:0] sext16_32(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

   function automatic logic [31:0] sext26_32(input logic [25:0] imm);
      return {{6{imm[25]}}, imm};
   endfunction

endpackage

// File: rtl/pc_target_calc.sv
// pc_target_calc
//   Combinational redirect target computation.
//   Ports:
//     redirect_type  in  2   branch / jump / jr (11 yields 0, caller ignores it)
//     redirect_pc    in  32  PC of the redirecting instruction
//     branch_imm16   in  16  signed word offset
//     jump_imm26     in  26  signed word offset
//     jr_target      in  32  absolute target, low two bits forced to zero
//     target         out 32  computed fetch address (mod 2^32)
module pc_target_calc
   import mips_pkg::*;
(
   input  logic [1:0]  redirect_type,
   input  logic [31:0] redirect_pc,
   input  logic [15:0] branch_imm16,
   input  logic [25:0] jump_imm26,
   input  logic [31:0] jr_target,
   output logic [31:0] target
);

   logic [31:0] seq_pc;

   assign seq_pc = redirect_pc + 32'd4;

   always_comb begin
      target = 32'h0000_0000;
      case (redirect_type)
         RD_BRANCH: target = seq_pc + (sext16_32(branch_imm16) << 2);
         RD_JUMP:   target = seq_pc + (sext26_32(jump_imm26) << 2);
         RD_JR:     target = jr_target & 32'hFFFF_FFFC;
         default:   target = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
//   Owns the program counter, fetches instructions over a req/ack port and
//   hands them to decode over valid/ready. Redirects from execute replace
//   the fetch address; an in-flight request is never withdrawn, its data is
//   discarded instead.
//   Ports:
//     clk, reset                    clock, synchronous active-high reset
//     imem_req/imem_addr            fetch request and address (registered)
//     imem_ack/imem_rdata           one-cycle ack with data
//     instr_valid/instr_ready       decode handshake
//     instr_out/instr_pc            held instruction and its address
//     redirect_valid/redirect_type  redirect strobe and kind
//     redirect_pc, branch_imm16, jump_imm26, jr_target  target operands
module pc_fetch_sequencer
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_out,
   output logic [31:0] instr_pc,
   input  logic        redirect_valid,
   input  logic [1:0]  redirect_type,
   input  logic [31:0] redirect_pc,
   input  logic [15:0] branch_imm16,
   input  logic [25:0] jump_imm26,
   input  logic [31:0] jr_target
);

   fetch_state_t state;
   logic [31:0]  fetch_pc;
   logic [31:0]  pend_pc;
   logic [31:0]  target;
   logic         redir;

   pc_target_calc u_target_calc (
      .redirect_type (redirect_type),
      .redirect_pc   (redirect_pc),
      .branch_imm16  (branch_imm16),
      .jump_imm26    (jump_imm26),
      .jr_target     (jr_target),
      .target        (target)
   );

   // The reserved encoding behaves exactly like no redirect at all.
   assign redir = redirect_valid && (redirect_type != 2'b11);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         fetch_pc    <= RESET_PC;
         pend_pc     <= RESET_PC;
         imem_req    <= 1'b0;
         imem_addr   <= RESET_PC;
         instr_valid <= 1'b0;
         instr_out   <= 32'h0000_0000;
         instr_pc    <= 32'h0000_0000;
      end else begin
         case (state)
            ST_IDLE: begin
               fetch_pc  <= redir ? target : fetch_pc;
               imem_addr <= redir ? target : fetch_pc;
               imem_req  <= 1'b1;
               state     <= ST_FETCH;
            end
            ST_FETCH: begin
               if (imem_ack) begin
                  if (redir) begin
                     // Returned word belongs to the abandoned path.
                     fetch_pc  <= target;
                     imem_addr <= target;
                     imem_req  <= 1'b1;
                  end else begin
                     instr_out   <= imem_rdata;
                     instr_pc    <= fetch_pc;
                     instr_valid <= 1'b1;
                     fetch_pc    <= fetch_pc + 32'd4;
                     imem_req    <= 1'b0;
                     state       <= ST_HOLD;
                  end
               end else if (redir) begin
                  // Request stays up at the old address until memory acks it.
                  pend_pc <= target;
                  state   <= ST_DISCARD;
               end
            end
            ST_HOLD: begin
               if (redir) begin
                  instr_valid <= 1'b0;
                  fetch_pc    <= target;
                  imem_addr   <= target;
                  imem_req    <= 1'b1;
                  state       <= ST_FETCH;
               end else if (instr_ready) begin
                  // Next request comes from state, not from ready combinationally.
                  instr_valid <= 1'b0;
                  imem_addr   <= fetch_pc;
                  imem_req    <= 1'b1;
                  state       <= ST_FETCH;
               end
            end
            ST_DISCARD: begin
               if (imem_ack) begin
                  fetch_pc  <= redir ? target : pend_pc;
                  imem_addr <= redir ? target : pend_pc;
                  imem_req  <= 1'b1;
                  state     <= ST_FETCH;
               end else if (redir) begin
                  pend_pc <= target;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
module tb_pc_fetch_sequencer;

   logic        clk = 1'b0;
   logic        rst1, rst2;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_ready;
   logic        redirect_valid;
   logic [1:0]  redirect_type;
   logic [31:0] redirect_pc;
   logic [15:0] branch_imm16;
   logic [25:0] jump_imm26;
   logic [31:0] jr_target;

   logic        req1, req2, vld1, vld2;
   logic [31:0] addr1, addr2, out1, out2, pc1, pc2;

   bit          sel;
   logic        cur_req, cur_vld;
   logic [31:0] cur_addr, cur_out, cur_pc;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] exp_addr_q[$];
   logic [63:0] exp_instr_q[$];

   always #5 clk = ~clk;

   pc_fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset(rst1),
      .imem_req(req1), .imem_addr(addr1), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_valid(vld1), .instr_ready(instr_ready), .instr_out(out1), .instr_pc(pc1),
      .redirect_valid(redirect_valid), .redirect_type(redirect_type), .redirect_pc(redirect_pc),
      .branch_imm16(branch_imm16), .jump_imm26(jump_imm26), .jr_target(jr_target)
   );

   pc_fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC)) dut_hi (
      .clk(clk), .reset(rst2),
      .imem_req(req2), .imem_addr(addr2), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_valid(vld2), .instr_ready(instr_ready), .instr_out(out2), .instr_pc(pc2),
      .redirect_valid(redirect_valid), .redirect_type(redirect_type), .redirect_pc(redirect_pc),
      .branch_imm16(branch_imm16), .jump_imm26(jump_imm26), .jr_target(jr_target)
   );

   assign cur_req  = sel ? req2  : req1;
   assign cur_vld  = sel ? vld2  : vld1;
   assign cur_addr = sel ? addr2 : addr1;
   assign cur_out  = sel ? out2  : out1;
   assign cur_pc   = sel ? pc2   : pc1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp_v);
      check(tag, {31'b0, obs}, {31'b0, exp_v});
   endtask

   // Wait for a request, compare its address with the scoreboard, then ack
   // after 'delay' cycles with 'data'.
   task automatic do_fetch(input int delay, input logic [31:0] data);
      logic [31:0] ea;
      int n;
      n = 0;
      while (!cur_req && n < 20) begin
         tick();
         n++;
      end
      check_bit("req_seen", cur_req, 1'b1);
      ea = (exp_addr_q.size() != 0) ? exp_addr_q.pop_front() : 32'hDEAD_BEEF;
      check("imem_addr", cur_addr, ea);
      for (int i = 0; i < delay; i++) begin
         tick();
         check("addr_stable", cur_addr, ea);
      end
      imem_ack   = 1'b1;
      imem_rdata = data;
      tick();
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
   endtask

   task automatic check_instr();
      logic [63:0] e;
      e = (exp_instr_q.size() != 0) ? exp_instr_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
      check_bit("instr_valid", cur_vld, 1'b1);
      check("instr_out", cur_out, e[63:32]);
      check("instr_pc", cur_pc, e[31:0]);
      check_bit("req_in_hold", cur_req, 1'b0);
   endtask

   task automatic pulse_redirect(input logic [1:0] ty, input logic [31:0] rpc,
                                 input logic [15:0] i16, input logic [25:0] i26,
                                 input logic [31:0] jr, input logic ack);
      redirect_valid = 1'b1;
      redirect_type  = ty;
      redirect_pc    = rpc;
      branch_imm16   = i16;
      jump_imm26     = i26;
      jr_target      = jr;
      imem_ack       = ack;
      tick();
      redirect_valid = 1'b0;
      imem_ack       = 1'b0;
   endtask

   initial begin
      sel = 1'b0;
      rst1 = 1'b1; rst2 = 1'b1;
      imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b1;
      redirect_valid = 1'b0; redirect_type = 2'b00; redirect_pc = 32'h0;
      branch_imm16 = 16'h0; jump_imm26 = 26'h0; jr_target = 32'h0;
      tick(); tick();

      // reset values
      check_bit("rst_req", cur_req, 1'b0);
      check("rst_addr", cur_addr, 32'h0);
      check_bit("rst_valid", cur_vld, 1'b0);
      check("rst_out", cur_out, 32'h0);
      check("rst_pc", cur_pc, 32'h0);
      rst1 = 1'b0;

      // sequential fetch 0x0, 0x4, 0x8, ack after 2 cycles
      for (int i = 0; i < 3; i++) begin
         exp_addr_q.push_back(32'(i * 4));
         exp_instr_q.push_back({32'hA000_0000 + 32'(i), 32'(i * 4)});
         do_fetch(2, 32'hA000_0000 + 32'(i));
         check_instr();
      end

      // decode stalls: output held, no request
      instr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_bit("stall_valid", cur_vld, 1'b1);
         check("stall_out", cur_out, 32'hA000_0002);
         check_bit("stall_req", cur_req, 1'b0);
      end

      // branch in HOLD (with ready raised the same cycle): 0x100+4-8 = 0xFC
      instr_ready = 1'b1;
      pulse_redirect(2'b00, 32'h100, 16'hFFFE, 26'h0, 32'h0, 1'b0);
      check_bit("br_valid_drop", cur_vld, 1'b0);
      check_bit("br_req", cur_req, 1'b1);
      check("br_addr", cur_addr, 32'h0FC);
      exp_addr_q.push_back(32'h0FC);
      exp_instr_q.push_back({32'hB000_0000, 32'h0FC});
      do_fetch(0, 32'hB000_0000);
      check_instr();

      // jump during unacked FETCH at 0x100: target 0x40+4-4 = 0x40
      tick();
      check("seq_addr", cur_addr, 32'h100);
      pulse_redirect(2'b01, 32'h40, 16'h0, 26'h3FF_FFFF, 32'h0, 1'b0);
      check("disc_hold_addr", cur_addr, 32'h100);
      check_bit("disc_req", cur_req, 1'b1);
      tick();
      check("disc_hold_addr2", cur_addr, 32'h100);
      imem_ack = 1'b1; imem_rdata = 32'hBAD0_0001;
      tick();
      imem_ack = 1'b0;
      check_bit("jmp_no_valid", cur_vld, 1'b0);
      check("jmp_addr", cur_addr, 32'h40);

      // second redirect (jr 0x203) while discarding overrides the jump
      pulse_redirect(2'b01, 32'h40, 16'h0, 26'h3FF_FFFF, 32'h0, 1'b0);
      pulse_redirect(2'b10, 32'h0, 16'h0, 26'h0, 32'h203, 1'b0);
      check("disc2_hold_addr", cur_addr, 32'h40);
      imem_ack = 1'b1; imem_rdata = 32'hBAD0_0002;
      tick();
      imem_ack = 1'b0;
      check_bit("jr_no_valid", cur_vld, 1'b0);
      exp_addr_q.push_back(32'h200);
      exp_instr_q.push_back({32'hC000_0000, 32'h200});
      do_fetch(1, 32'hC000_0000);
      check_instr();

      // redirect and ack on the same FETCH cycle
      tick();
      check("pre_same_addr", cur_addr, 32'h204);
      pulse_redirect(2'b10, 32'h0, 16'h0, 26'h0, 32'h1000, 1'b1);
      check_bit("same_no_valid", cur_vld, 1'b0);
      check("same_addr", cur_addr, 32'h1000);
      tick();
      check_bit("same_no_valid2", cur_vld, 1'b0);

      // reserved redirect type held through the fetch has no effect
      redirect_valid = 1'b1; redirect_type = 2'b11; jr_target = 32'h7770;
      exp_addr_q.push_back(32'h1000);
      exp_instr_q.push_back({32'hD000_0000, 32'h1000});
      do_fetch(1, 32'hD000_0000);
      redirect_valid = 1'b0; redirect_type = 2'b00;
      check_instr();

      // RESET_PC = 0xFFFF_FFFC instance
      rst1 = 1'b1;
      sel  = 1'b1;
      tick();
      check("hi_rst_addr", cur_addr, 32'hFFFF_FFFC);
      check_bit("hi_rst_req", cur_req, 1'b0);
      rst2 = 1'b0;
      exp_addr_q.push_back(32'hFFFF_FFFC);
      exp_instr_q.push_back({32'hE000_0000, 32'hFFFF_FFFC});
      do_fetch(0, 32'hE000_0000);
      check_instr();
      tick();
      check("wrap_addr", cur_addr, 32'h0);
      check_bit("wrap_req", cur_req, 1'b1);
      pulse_redirect(2'b00, 32'h100, 16'h0010, 26'h0, 32'h0, 1'b0);
      check("hi_disc_addr", cur_addr, 32'h0);

      // reset in DISCARD together with an ack
      rst2 = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0003;
      tick();
      check_bit("midrst_req", cur_req, 1'b0);
      check("midrst_addr", cur_addr, 32'hFFFF_FFFC);
      check_bit("midrst_valid", cur_vld, 1'b0);
      rst2 = 1'b0;
      tick();
      imem_ack = 1'b0;
      check_bit("late_ack_req", cur_req, 1'b1);
      check("late_ack_addr", cur_addr, 32'hFFFF_FFFC);
      check_bit("late_ack_valid", cur_vld, 1'b0);
      tick();
      check_bit("late_ack_valid2", cur_vld, 1'b0);
      check("late_ack_addr2", cur_addr, 32'hFFFF_FFFC);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
